// File: rtl/noc_pkg.sv
// Shared constants, types and request-decode helper for the 5-port NoC switch.
package noc_pkg;

    localparam int unsigned DW     = 8;
    localparam int unsigned NPORT  = 5;
    localparam int unsigned PW     = 3;
    localparam int unsigned NO_REQ = 5;

    localparam int unsigned PORT_L = 0;
    localparam int unsigned PORT_N = 1;
    localparam int unsigned PORT_E = 2;
    localparam int unsigned PORT_S = 3;
    localparam int unsigned PORT_W = 4;

    typedef logic [DW-1:0] flit_t;
    typedef logic [PW-1:0] dest_t;

    // A request from src targets dst only if it names dst and is not a U-turn.
    function automatic logic req_valid(dest_t dest, int unsigned src, int unsigned dst);
        return (32'(dest) < NO_REQ) && (32'(dest) == dst) && (src != dst);
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Five-way round-robin arbiter: one-hot grant, search starts after the last winner.
module rr_arbiter5
    import noc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPORT-1:0] req,
    input  logic             en,
    output logic [NPORT-1:0] grant_c
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] cand;
    logic          found;

    // Scan inputs in order ptr+1, ptr+2, ... modulo NPORT.
    always_comb begin
        grant_c = '0;
        win     = ptr;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NPORT; k++) begin
            cand = PW'((32'(ptr) + k) % NPORT);
            if (!found && en && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (found) begin
            grant_c[win] = 1'b1;
        end
    end

    // Pointer starts at W so that L is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PW'(PORT_W);
        end else if (found) begin
            ptr <= win;
        end
    end

endmodule

// File: rtl/noc_switch.sv
// 5-port NoC crossbar: request decode, per-output round-robin arbitration, registered outputs.
module noc_switch
    import noc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] In_L,
    input  logic [DW-1:0] In_N,
    input  logic [DW-1:0] In_E,
    input  logic [DW-1:0] In_S,
    input  logic [DW-1:0] In_W,
    input  logic [PW-1:0] request_L,
    input  logic [PW-1:0] request_N,
    input  logic [PW-1:0] request_E,
    input  logic [PW-1:0] request_S,
    input  logic [PW-1:0] request_W,
    input  logic          full_L,
    input  logic          full_N,
    input  logic          full_E,
    input  logic          full_S,
    input  logic          full_W,
    output logic [DW-1:0] Out_L,
    output logic [DW-1:0] Out_N,
    output logic [DW-1:0] Out_E,
    output logic [DW-1:0] Out_S,
    output logic [DW-1:0] Out_W,
    output logic          grant_L,
    output logic          grant_N,
    output logic          grant_E,
    output logic          grant_S,
    output logic          grant_W
);

    flit_t            in_a   [NPORT];
    dest_t            req_a  [NPORT];
    logic [NPORT-1:0] full_v;
    logic [NPORT-1:0] req_m  [NPORT];
    logic [NPORT-1:0] arb_gnt[NPORT];
    flit_t            mux_d  [NPORT];
    logic [NPORT-1:0] gnt_in;
    flit_t            out_q  [NPORT];
    logic [NPORT-1:0] grant_q;

    assign in_a[PORT_L]  = In_L;
    assign in_a[PORT_N]  = In_N;
    assign in_a[PORT_E]  = In_E;
    assign in_a[PORT_S]  = In_S;
    assign in_a[PORT_W]  = In_W;
    assign req_a[PORT_L] = request_L;
    assign req_a[PORT_N] = request_N;
    assign req_a[PORT_E] = request_E;
    assign req_a[PORT_S] = request_S;
    assign req_a[PORT_W] = request_W;
    assign full_v        = {full_W, full_S, full_E, full_N, full_L};

    // req_m[p][i]: input i holds a valid request for output p.
    always_comb begin
        for (int unsigned p = 0; p < NPORT; p++) begin
            req_m[p] = '0;
            for (int unsigned i = 0; i < NPORT; i++) begin
                req_m[p][i] = req_valid(req_a[i], i, p);
            end
        end
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_arb
        rr_arbiter5 u_arb (
            .clk     (clk),
            .rst_n   (rst),
            .req     (req_m[p]),
            .en      (!full_v[p]),
            .grant_c (arb_gnt[p])
        );
    end

    // One-hot grant selects the flit per output; grants OR-reduce per input.
    always_comb begin
        gnt_in = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            mux_d[p] = '0;
            for (int unsigned i = 0; i < NPORT; i++) begin
                if (arb_gnt[p][i]) begin
                    mux_d[p] = mux_d[p] | in_a[i];
                end
                gnt_in[i] = gnt_in[i] | arb_gnt[p][i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned p = 0; p < NPORT; p++) begin
                out_q[p] <= '0;
            end
            grant_q <= '0;
        end else begin
            for (int unsigned p = 0; p < NPORT; p++) begin
                if (|arb_gnt[p]) begin
                    out_q[p] <= mux_d[p];
                end
            end
            grant_q <= gnt_in;
        end
    end

    assign Out_L   = out_q[PORT_L];
    assign Out_N   = out_q[PORT_N];
    assign Out_E   = out_q[PORT_E];
    assign Out_S   = out_q[PORT_S];
    assign Out_W   = out_q[PORT_W];
    assign grant_L = grant_q[PORT_L];
    assign grant_N = grant_q[PORT_N];
    assign grant_E = grant_q[PORT_E];
    assign grant_S = grant_q[PORT_S];
    assign grant_W = grant_q[PORT_W];

endmodule

// File: tb/tb_noc_switch.sv
// Directed vector bench for noc_switch; port index order is L,N,E,S,W = 0..4.
module tb_noc_switch;

    typedef struct {
        logic [4:0][2:0] req;
        logic [4:0][7:0] din;
        logic [4:0]      full;
        logic [4:0][7:0] eout;
        logic [4:0]      egnt;
    } vec_t;

    localparam int NV = 13;

    logic            clk;
    logic            rst;
    logic [4:0][2:0] req;
    logic [4:0][7:0] din;
    logic [4:0]      full;
    logic [7:0]      Out_L, Out_N, Out_E, Out_S, Out_W;
    logic            grant_L, grant_N, grant_E, grant_S, grant_W;
    logic [4:0][7:0] outs;
    logic [4:0]      gnts;
    vec_t            tv [NV];
    int              checks;
    int              errors;

    noc_switch dut (
        .clk       (clk),
        .rst       (rst),
        .In_L      (din[0]),
        .In_N      (din[1]),
        .In_E      (din[2]),
        .In_S      (din[3]),
        .In_W      (din[4]),
        .request_L (req[0]),
        .request_N (req[1]),
        .request_E (req[2]),
        .request_S (req[3]),
        .request_W (req[4]),
        .full_L    (full[0]),
        .full_N    (full[1]),
        .full_E    (full[2]),
        .full_S    (full[3]),
        .full_W    (full[4]),
        .Out_L     (Out_L),
        .Out_N     (Out_N),
        .Out_E     (Out_E),
        .Out_S     (Out_S),
        .Out_W     (Out_W),
        .grant_L   (grant_L),
        .grant_N   (grant_N),
        .grant_E   (grant_E),
        .grant_S   (grant_S),
        .grant_W   (grant_W)
    );

    always_comb outs = {Out_W, Out_S, Out_E, Out_N, Out_L};
    always_comb gnts = {grant_W, grant_S, grant_E, grant_N, grant_L};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0][7:0] eo, input logic [4:0] eg);
        for (int p = 0; p < 5; p++) begin
            chk($sformatf("%s out%0d", tag, p), outs[p], eo[p]);
        end
        chk($sformatf("%s grants", tag), 8'(gnts), 8'(eg));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [4:0][2:0] r, input logic [4:0][7:0] d,
                                input logic [4:0] f, input logic [4:0][7:0] eo,
                                input logic [4:0] eg);
        vec_t v;
        v.req = r; v.din = d; v.full = f; v.eout = eo; v.egnt = eg;
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        // Fields are {W,S,E,N,L}.
        tv[0]  = mk({3'd7,3'd7,3'd7,3'd7,3'd7}, {8'd5,8'd4,8'd3,8'd2,8'd1}, 5'b00000,
                    {8'd0,8'd0,8'd0,8'd0,8'd0}, 5'b00000);
        tv[1]  = mk({3'd0,3'd7,3'd7,3'd7,3'd7}, {8'd4,8'd4,8'd3,8'd2,8'd1}, 5'b00000,
                    {8'd0,8'd0,8'd0,8'd0,8'd4}, 5'b10000);
        tv[2]  = mk({3'd0,3'd7,3'd7,3'd7,3'd7}, {8'd5,8'd4,8'd3,8'd2,8'd1}, 5'b00001,
                    {8'd0,8'd0,8'd0,8'd0,8'd4}, 5'b00000);
        tv[3]  = mk({3'd0,3'd7,3'd7,3'd7,3'd7}, {8'd6,8'd4,8'd3,8'd2,8'd1}, 5'b00001,
                    {8'd0,8'd0,8'd0,8'd0,8'd4}, 5'b00000);
        tv[4]  = mk({3'd0,3'd7,3'd7,3'd7,3'd7}, {8'd7,8'd4,8'd3,8'd2,8'd1}, 5'b00000,
                    {8'd0,8'd0,8'd0,8'd0,8'd7}, 5'b10000);
        tv[5]  = mk({3'd0,3'd2,3'd0,3'd7,3'd7}, {8'd7,8'd5,8'd3,8'd2,8'd1}, 5'b00000,
                    {8'd0,8'd0,8'd5,8'd0,8'd3}, 5'b01100);
        tv[6]  = mk({3'd0,3'd2,3'd0,3'd7,3'd7}, {8'd7,8'd5,8'd3,8'd2,8'd1}, 5'b00000,
                    {8'd0,8'd0,8'd5,8'd0,8'd7}, 5'b11000);
        tv[7]  = mk({3'd0,3'd2,3'd0,3'd7,3'd7}, {8'd7,8'd5,8'd3,8'd2,8'd1}, 5'b00000,
                    {8'd0,8'd0,8'd5,8'd0,8'd3}, 5'b01100);
        tv[8]  = mk({3'd0,3'd2,3'd0,3'd7,3'd7}, {8'd7,8'd5,8'd3,8'd2,8'd1}, 5'b00000,
                    {8'd0,8'd0,8'd5,8'd0,8'd7}, 5'b11000);
        tv[9]  = mk({3'd7,3'd7,3'd7,3'd1,3'd6}, {8'd7,8'd5,8'd3,8'd2,8'd1}, 5'b00000,
                    {8'd0,8'd0,8'd5,8'd0,8'd7}, 5'b00000);
        tv[10] = mk({3'd0,3'd2,3'd0,3'd7,3'd7}, {8'd7,8'd5,8'd3,8'd2,8'd1}, 5'b00100,
                    {8'd0,8'd0,8'd5,8'd0,8'd3}, 5'b00100);
        tv[11] = mk({3'd0,3'd2,3'd0,3'd7,3'd7}, {8'd7,8'd9,8'd3,8'd2,8'd1}, 5'b00000,
                    {8'd0,8'd0,8'd9,8'd0,8'd7}, 5'b11000);
        tv[12] = mk({3'd2,3'd0,3'd4,3'd3,3'd1}, {8'h55,8'h44,8'h33,8'h22,8'h11}, 5'b00000,
                    {8'h33,8'h22,8'h55,8'h11,8'h44}, 5'b11111);

        // Idle inputs, reset pulse of 25 ns.
        rst  = 1'b1;
        req  = {3'd7,3'd7,3'd7,3'd7,3'd7};
        din  = {8'd5,8'd4,8'd3,8'd2,8'd1};
        full = '0;
        #2 rst = 1'b0;
        #1 chk_all("in_reset", '0, '0);
        #24 rst = 1'b1;
        @(negedge clk);
        chk_all("post_reset0", '0, '0);
        step();
        chk_all("post_reset1", '0, '0);

        for (int i = 0; i < NV; i++) begin
            req  = tv[i].req;
            din  = tv[i].din;
            full = tv[i].full;
            step();
            chk_all($sformatf("v%0d", i), tv[i].eout, tv[i].egnt);
        end

        // Contention again, then async reset between edges; L pointer was left at S.
        req  = {3'd0,3'd2,3'd0,3'd7,3'd7};
        din  = {8'd7,8'd5,8'd3,8'd2,8'd1};
        full = '0;
        step();
        chk_all("pre_mid_reset", {8'h33,8'h22,8'd5,8'h11,8'd7}, 5'b11000);
        #2 rst = 1'b0;
        #1 chk_all("mid_reset", '0, '0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk_all("after_mid_reset0", {8'd0,8'd0,8'd5,8'd0,8'd3}, 5'b01100);
        step();
        chk_all("after_mid_reset1", {8'd0,8'd0,8'd5,8'd0,8'd7}, 5'b11000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
